// File: rtl/example_adder_pipe.sv
// Pipelined add/sub/accumulate engine over WIDTH-bit operands with carry/borrow and signed-overflow flags.
// Latency STAGES cycles when unstalled, 1 beat/cycle; EXAMPLE_ADDER_SAT_EN adds unsigned saturation.
// Global stall: the whole pipe advances only when the output slot is empty or being consumed; in_ready mirrors that.
module example_adder_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             ovf_out
);

    localparam int MSB = WIDTH - 1;

    localparam logic [1:0] MODE_ADD  = 2'b00;
    localparam logic [1:0] MODE_SUB  = 2'b01;
    localparam logic [1:0] MODE_ACC  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] sum;
        logic             carry;
        logic             ovf;
    } stage_t;

    stage_t           pipe [STAGES];
    logic [WIDTH-1:0] acc;

    logic             advance;
    logic             accept;
    logic [WIDTH-1:0] opb;
    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] res_sum;
    logic             res_carry;
    logic             res_ovf;

    assign advance  = !pipe[STAGES-1].vld | out_ready;
    assign in_ready = advance;
    assign accept   = in_valid & advance;

    // Accumulate mode reuses the adder with the accumulator standing in for B.
    always_comb begin
        opb       = mode[1] ? acc : b_in;
        wide      = '0;
        res_sum   = '0;
        res_carry = 1'b0;
        res_ovf   = 1'b0;
        case (mode)
            MODE_ADD, MODE_ACC: begin
                wide      = {1'b0, a_in} + {1'b0, opb};
                res_carry = wide[WIDTH];
                res_ovf   = (a_in[MSB] == opb[MSB]) & (wide[MSB] != a_in[MSB]);
                res_sum   = wide[MSB:0];
`ifdef EXAMPLE_ADDER_SAT_EN
                if (res_carry) begin
                    res_sum = '1;
                end
`endif
            end
            MODE_SUB: begin
                // Bit WIDTH of the zero-extended difference is exactly the unsigned borrow.
                wide      = {1'b0, a_in} - {1'b0, b_in};
                res_carry = wide[WIDTH];
                res_ovf   = (a_in[MSB] != b_in[MSB]) & (wide[MSB] != a_in[MSB]);
                res_sum   = wide[MSB:0];
`ifdef EXAMPLE_ADDER_SAT_EN
                if (res_carry) begin
                    res_sum = '0;
                end
`endif
            end
            MODE_LOAD: begin
                res_sum = a_in;
            end
            default: begin
                res_sum = a_in;
            end
        endcase
    end

    // The accumulator commits on the same edge as stage 1, so back-to-back acc beats chain directly.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pipe[0] <= '0;
            acc     <= '0;
        end else if (advance) begin
            pipe[0].vld   <= in_valid;
            pipe[0].sum   <= res_sum;
            pipe[0].carry <= res_carry;
            pipe[0].ovf   <= res_ovf;
            if (accept && mode[1]) begin
                acc <= res_sum;
            end
        end
    end

    for (genvar g = 1; g < STAGES; g++) begin : g_delay
        always_ff @(posedge clk) begin
            if (!rst) begin
                pipe[g] <= '0;
            end else if (advance) begin
                pipe[g] <= pipe[g-1];
            end
        end
    end

    assign out_valid = pipe[STAGES-1].vld;
    assign sum_out   = pipe[STAGES-1].sum;
    assign carry_out = pipe[STAGES-1].carry;
    assign ovf_out   = pipe[STAGES-1].ovf;

endmodule
